// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the seven-segment scan controller.
package seg7_pkg;
    typedef enum logic {BLANK, DRIVE} state_t;
    localparam logic [3:0] ANODES_OFF  = 4'hF;
    localparam logic [7:0] CATHODE_OFF = 8'hFF;
    // Active-low g..a patterns for hex 0..F; dp is handled separately.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational hex nibble to active-low g..a segment decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    always_comb seg = SEG_LUT[nib];
endmodule

// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller: multiplexes a buffered 16-bit hex word onto a 4-digit
// common-bus seven-segment display with per-slot blanking and frame-aligned updates.
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_value,
    input  logic [3:0]  in_dp,
    input  logic [3:0]  in_digit_en,
    input  logic        lz_blank,
    output logic [3:0]  anode,
    output logic [7:0]  cathode,
    output logic        frame_done
);
    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic          full, last, boundary, lit;
    logic [15:0]   pend_val, act_val;
    logic [3:0]    pend_dp, pend_en, act_dp, act_en, nib;
    logic          pend_lz, act_lz;
    logic [6:0]    seg;

    always_comb begin
        last     = cnt == CW'(REFRESH_DIV - 1);
        boundary = state == DRIVE && last && idx == 2'd3;
        state_nx = state;
        if (state == BLANK && cnt == CW'(BLANK_CYCLES - 1))
            state_nx = DRIVE;
        else if (state == DRIVE && last)
            state_nx = BLANK;
        nib = act_val[idx*4 +: 4];
        // Leading-zero blanking darkens digit i when nibbles i..3 are all zero.
        lit = state == DRIVE && act_en[idx] &&
              !(act_lz && idx != 2'd0 && (act_val >> {idx, 2'b00}) == 16'd0);
    end

    hex_to_seg7 u_dec (.nib(nib), .seg(seg));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BLANK;
            cnt      <= '0;
            idx      <= '0;
            full     <= 1'b0;
            pend_val <= '0;
            pend_dp  <= '0;
            pend_en  <= '0;
            pend_lz  <= 1'b0;
            act_val  <= '0;
            act_dp   <= '0;
            act_en   <= '0;
            act_lz   <= 1'b0;
            anode    <= ANODES_OFF;
            cathode  <= CATHODE_OFF;
        end else begin
            state   <= state_nx;
            cnt     <= last ? '0 : cnt + 1'b1;
            idx     <= (state == DRIVE && last) ? idx + 2'd1 : idx;
            anode   <= lit ? ~(4'b0001 << idx) : ANODES_OFF;
            cathode <= lit ? {~act_dp[idx], seg} : CATHODE_OFF;
            if (boundary && full) begin
                act_val <= pend_val;
                act_dp  <= pend_dp;
                act_en  <= pend_en;
                act_lz  <= pend_lz;
                full    <= 1'b0;
            end else if (in_valid && !full) begin
                pend_val <= in_value;
                pend_dp  <= in_dp;
                pend_en  <= in_digit_en;
                pend_lz  <= lz_blank;
                full     <= 1'b1;
            end
        end
    end

    assign in_ready   = !full;
    assign frame_done = boundary;
endmodule

// File: tb/tb_seg7_scan_controller.sv
// tb_seg7_scan_controller: randomized bench comparing the scan controller against
// a frame/slot arithmetic model of the display timing and word buffering.
module tb_seg7_scan_controller;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [15:0] v;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic        lz;
    } word_t;

    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, lz_blank = 1'b0;
    logic        in_ready, frame_done;
    logic [15:0] in_value = '0;
    logic [3:0]  in_dp = '0, in_digit_en = '0, anode;
    logic [7:0]  cathode;

    int          vec_cnt = 0, err_cnt = 0;
    word_t       act, pend, cur;
    bit          pend_full;
    int          k;
    logic [11:0] exp_pins;
    word_t       dq[$];

    seg7_scan_controller #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_value(in_value), .in_dp(in_dp), .in_digit_en(in_digit_en),
        .lz_blank(lz_blank), .anode(anode), .cathode(cathode),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s at k=%0d: got %0h expected %0h", tag, k, got, exp);
        end
    endtask

    function automatic logic [11:0] pins_for(input word_t a, input int d, input bit drive);
        logic [3:0] an;
        logic [3:0] nb;
        bit lit;
        an = 4'hF;
        an[d] = 1'b0;
        nb = a.v[d*4 +: 4];
        lit = drive && a.en[d] && !(a.lz && d > 0 && (a.v >> (4*d)) == 16'd0);
        return lit ? {an, ~a.dp[d], SEG_TAB[nb]} : 12'hFFF;
    endfunction

    function automatic word_t rand_word();
        word_t w;
        w.v  = 16'($urandom) >> (4 * $urandom_range(0, 4));
        w.dp = 4'($urandom);
        w.en = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
        w.lz = 1'($urandom);
        return w;
    endfunction

    task automatic model_reset();
        k = 0;
        act = '0;
        pend = '0;
        pend_full = 0;
        exp_pins = 12'hFFF;
    endtask

    // Called at a falling edge: check pins, drive inputs, predict the next cycle.
    task automatic step();
        int phase, digit;
        check("anode", 32'(anode), 32'(exp_pins[11:8]));
        check("cathode", 32'(cathode), 32'(exp_pins[7:0]));
        check("in_ready", 32'(in_ready), 32'(!pend_full));
        check("frame_done", 32'(frame_done), 32'(k % (4*RD) == 4*RD - 1));
        if (!pend_full) cur = (dq.size() > 0) ? dq[0] : rand_word();
        in_valid = ($urandom_range(0, 15) == 0);
        {in_value, in_dp, in_digit_en, lz_blank} = cur;
        phase = k % RD;
        digit = (k / RD) % 4;
        exp_pins = pins_for(act, digit, phase >= BC);
        if (phase == RD - 1 && digit == 3 && pend_full) begin
            act = pend;
            pend_full = 0;
        end else if (in_valid && !pend_full) begin
            pend = cur;
            pend_full = 1;
            if (dq.size() > 0) void'(dq.pop_front());
        end
        k++;
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        dq.push_back({16'h1234, 4'h0, 4'hF, 1'b0});
        dq.push_back({16'hABCD, 4'h0, 4'hF, 1'b0});
        dq.push_back({16'h0050, 4'h0, 4'hF, 1'b1});
        dq.push_back({16'h0050, 4'h0, 4'hF, 1'b0});
        dq.push_back({16'h0008, 4'h2, 4'hF, 1'b0});
        dq.push_back({16'h0008, 4'h2, 4'hE, 1'b0});
        repeat (3) @(negedge clk);
        check("rst_anode", 32'(anode), 32'h F);
        check("rst_cathode", 32'(cathode), 32'hFF);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        repeat (4*RD*40 + 2*RD + 5) step();
        #1 rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("async_anode", 32'(anode), 32'hF);
        check("async_cathode", 32'(cathode), 32'hFF);
        check("async_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4*RD*10) step();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
